// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} seq_state_t;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned LEN_W       = $clog2(DEF_MAX_LEN + 1);

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a clear request takes priority over an increment.
module seq_match_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins, otherwise increment until all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// in_valid qualification and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN         = 8,
  parameter int unsigned        CNT_W           = 16,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(4'b1011),
  parameter int unsigned        DEFAULT_LEN     = 4,
  localparam int unsigned       LW              = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam logic [LW-1:0] LEN_ONE = LW'(1);

  seq_state_t         state_r, state_nx_s;
  logic [MAX_LEN-1:0] pat_r, pat_nx_s, hist_r, hist_nx_s, mask_s, cand_s;
  logic [LW-1:0]      len_r, len_nx_s, fill_r, fill_nx_s;
  logic               ovl_r, ovl_nx_s, out_r, out_nx_s;
  logic               in_bit_s, cfg_load_s, accept_s, full_s, match_s;

  // Qualified input bit, candidate window and masked compare (X on in is blocked when idle).
  always_comb begin
    cfg_load_s = cfg_we && (cfg_len != {LW{1'b0}});
    accept_s   = in_valid && !cfg_load_s;
    if (in_valid) begin
      in_bit_s = in;
    end else begin
      in_bit_s = 1'b0;
    end
    cand_s = (hist_r << 1) | MAX_LEN'(in_bit_s);
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LW'(i) < len_r);
    end
    // The bit arriving now completes the window when fill is one short of len.
    full_s  = (state_r == ARMED) || (fill_r == (len_r - LEN_ONE));
    match_s = accept_s && full_s && ((cand_s & mask_s) == (pat_r & mask_s));
  end

  // Next-state: config load beats a same-cycle data bit; non-overlap restarts the fill.
  always_comb begin
    state_nx_s = state_r;
    pat_nx_s   = pat_r;
    len_nx_s   = len_r;
    ovl_nx_s   = ovl_r;
    hist_nx_s  = hist_r;
    fill_nx_s  = fill_r;
    out_nx_s   = 1'b0;
    if (cfg_load_s) begin
      pat_nx_s   = cfg_pattern;
      len_nx_s   = LW'(clamp_len(32'(cfg_len), MAX_LEN));
      ovl_nx_s   = cfg_overlap;
      hist_nx_s  = {MAX_LEN{1'b0}};
      fill_nx_s  = {LW{1'b0}};
      state_nx_s = FILL;
    end else if (accept_s) begin
      out_nx_s  = match_s;
      hist_nx_s = cand_s;
      if (match_s && !ovl_r) begin
        hist_nx_s  = {MAX_LEN{1'b0}};
        fill_nx_s  = {LW{1'b0}};
        state_nx_s = FILL;
      end else begin
        if (fill_r < len_r) begin
          fill_nx_s = fill_r + LEN_ONE;
        end else begin
          fill_nx_s = fill_r;
        end
        if (fill_nx_s == len_r) begin
          state_nx_s = ARMED;
        end else begin
          state_nx_s = FILL;
        end
      end
    end else begin
      out_nx_s = 1'b0;
    end
  end

  // State, configuration, history and strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FILL;
      pat_r   <= DEFAULT_PATTERN;
      len_r   <= LW'(DEFAULT_LEN);
      ovl_r   <= 1'b1;
      hist_r  <= {MAX_LEN{1'b0}};
      fill_r  <= {LW{1'b0}};
      out_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pat_r   <= pat_nx_s;
      len_r   <= len_nx_s;
      ovl_r   <= ovl_nx_s;
      hist_r  <= hist_nx_s;
      fill_r  <= fill_nx_s;
      out_r   <= out_nx_s;
    end
  end

  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_s),
    .clr   (clr_count),
    .count (match_count)
  );

  assign out   = out_r;
  assign armed = (state_r == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomized and directed bench for seq_detector_param against a queue-based reference model.
module tb_seq_detector_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = 8'd0;
  logic [3:0]  cfg_len = 4'd0;
  logic        cfg_overlap = 1'b0;
  logic        clr_count = 1'b0;
  logic        in_valid = 1'b0;
  logic        din = 1'b0;
  logic        out_a, armed_a, out_b, armed_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int vectors = 0;
  int miscompares = 0;

  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_q[$];
  int       m_cnt_a, m_cnt_b;
  bit       e_out;

  bit stream7 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count), .in_valid(in_valid), .in(din),
    .out(out_a), .match_count(cnt_a), .armed(armed_a)
  );

  seq_detector_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count), .in_valid(in_valid), .in(din),
    .out(out_b), .match_count(cnt_b), .armed(armed_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b0000_1011;
    m_len = 4;
    m_ovl = 1'b1;
    m_q.delete();
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // Apply one cycle of stimulus, advance the model, then check both DUTs after the edge.
  task automatic step(input bit we, input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                      input bit clr, input bit v, input logic b);
    bit hit;
    cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    clr_count = clr; in_valid = v;
    din = v ? b : 1'bx;
    hit = 1'b0;
    if (we && (len != 4'd0)) begin
      m_pat = pat;
      m_len = (len > 4'd8) ? 8 : int'(len);
      m_ovl = ovl;
      m_q.delete();
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() > 8) void'(m_q.pop_front());
      if (m_q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (m_q[m_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
      end
      if (hit && !m_ovl) m_q.delete();
    end
    e_out = hit;
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    @(posedge clk);
    #1;
    check_val("out_a", 32'(out_a), 32'(e_out));
    check_val("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
    check_val("armed_a", 32'(armed_a), 32'(m_q.size() >= m_len));
    check_val("out_b", 32'(out_b), 32'(e_out));
    check_val("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'bx);
  endtask

  initial begin
    model_reset();
    #12;
    check_val("rst_out", 32'(out_a), 32'd0);
    check_val("rst_cnt", 32'(cnt_a), 32'd0);
    check_val("rst_armed", 32'(armed_a), 32'd0);
    rst = 1'b1;

    // 1: defaults, overlapping
    for (int i = 0; i < 7; i++) begin
      bit_in(stream7[i]);
      if (i == 3 || i == 6) check_val("t1_pulse", 32'(out_a), 32'd1);
    end
    check_val("t1_cnt", 32'(cnt_a), 32'd2);

    // 2: non-overlapping 1011
    step(1'b1, 8'b1011, 4'd4, 1'b0, 1'b1, 1'b0, 1'bx);
    for (int i = 0; i < 7; i++) begin
      bit_in(stream7[i]);
      if (i == 3) check_val("t2_armed", 32'(armed_a), 32'd0);
    end
    check_val("t2_cnt", 32'(cnt_a), 32'd1);

    // 3: all-zero pattern across idle gaps
    step(1'b1, 8'b000, 4'd3, 1'b1, 1'b1, 1'b0, 1'bx);
    bit_in(1'b0);
    bit_in(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_val("t3_gap", 32'(out_a), 32'd0);
    end
    bit_in(1'b0);
    check_val("t3_pulse", 32'(out_a), 32'd1);

    // 4: config write mid-stream drops the same-cycle bit; zero-length write ignored
    bit_in(1'b1);
    bit_in(1'b0);
    step(1'b1, 8'b11, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("t4_armed", 32'(armed_a), 32'd0);
    bit_in(1'b1);
    bit_in(1'b1);
    check_val("t4_pulse", 32'(out_a), 32'd1);
    step(1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'bx);
    check_val("t4_len0_armed", 32'(armed_a), 32'd1);
    bit_in(1'b1);
    check_val("t4_len0_pulse", 32'(out_a), 32'd1);

    // 5: len-1 pattern, saturating 2-bit counter, clear beats a match
    step(1'b1, 8'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'bx);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1);
      check_val("t5_sat", 32'(cnt_b), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_val("t5_clr", 32'(cnt_b), 32'd0);

    // 6: asynchronous reset between edges, defaults restored
    step(1'b1, 8'b1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'bx);
    for (int i = 0; i < 4; i++) bit_in(stream7[i]);
    #3 rst = 1'b0;
    #1;
    check_val("t6_out", 32'(out_a), 32'd0);
    check_val("t6_cnt", 32'(cnt_a), 32'd0);
    check_val("t6_armed", 32'(armed_a), 32'd0);
    model_reset();
    #2 rst = 1'b1;
    step(1'b1, 8'b0110, 4'd0, 1'b0, 1'b0, 1'b0, 1'bx);
    for (int i = 0; i < 4; i++) bit_in(stream7[i]);
    check_val("t6_default", 32'(out_a), 32'd1);

    // Random phase, including clamped lengths and config collisions
    for (int n = 0; n < 400; n++) begin
      bit       we, clr, v, ovl;
      bit [7:0] pat;
      bit [3:0] len;
      we  = ($urandom_range(0, 99) < 5);
      clr = ($urandom_range(0, 99) < 3);
      v   = ($urandom_range(0, 99) < 70);
      ovl = $urandom_range(0, 1) != 0;
      pat = 8'($urandom);
      len = 4'($urandom_range(0, 15));
      if (we && len > 4'd5 && $urandom_range(0, 1) != 0) len = 4'($urandom_range(1, 3));
      step(we, pat, len, ovl, clr, v, logic'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
